fetch_instruction_buffer: RTL and testbench
===========================================

Name: fetch_instruction_buffer

Overview:
- Sits between the instruction memory response and the decode stage, directly downstream of the program counter controller.
- Queues fetched instruction/PC pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Drives buble back to the PC controller when it cannot accept a word.
- Predecodes the incoming word (JAL/JALR detection, sign-extended immediate) so the PC controller can form the next fetch address in the same cycle.

Parameters:
size, 32, PC and instruction width in bits.
DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
imem_valid  input  1  instruction memory word valid this cycle
imem_instr  input  size  fetched instruction
imem_pc  input  size  PC of the fetched instruction
flush  input  1  misprediction flush from execute
dec_ready  input  1  decode accepts the head entry this cycle
dec_valid  output  1  head entry valid
dec_instr  output  size  head instruction
dec_pc  output  size  head PC
buble  output  1  stall to PC controller; equals full
jump  output  1  incoming word is JAL (opcode 7'b1101111)
jalr  output  1  incoming word is JALR (opcode 7'b1100111)
imm_i  output  size  sign-extended immediate of incoming word

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr and count clear to 0.
  - dec_valid=0, buble=0.
  - dec_instr=32'h00000013 (NOP), dec_pc=0.
  - Storage contents are don't-care.
- Storage and pointers:
  - count width is clog2(DEPTH)+1; pointers are clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Enqueue:
  - enq = imem_valid & ~full & ~flush.
  - Writes {imem_instr, imem_pc} at wr_ptr on the clock edge.
- Dequeue:
  - deq = dec_valid & dec_ready & ~flush.
  - Advances rd_ptr.
- Handshake:
  - dec_valid = ~empty (registered state, no combinational path from imem_valid).
  - Latency from enqueue to dec_valid is exactly 1 cycle; there is no bypass.
  - dec_instr/dec_pc show the entry at rd_ptr when valid, otherwise NOP and 0.
  - dec_instr/dec_pc are stable while dec_valid=1 and dec_ready=0.
- Simultaneous events:
  - enq and deq in the same cycle: count unchanged, both pointers advance.
  - When full, enq is blocked even if deq occurs that cycle. buble is derived from count only, so it never depends combinationally on dec_ready.
  - When full, the upstream word is not consumed. The PC controller is held by buble and re-presents the same word.
- Flush has priority over everything:
  - On the edge with flush=1: count, wr_ptr and rd_ptr clear to 0.
  - The incoming word is discarded and no dequeue is counted.
  - dec_valid=0 and buble=0 the following cycle.
- Predecode (combinational, on the incoming imem_instr):
  - jump = imem_valid & ~flush & (opcode==1101111).
  - jalr = imem_valid & ~flush & (opcode==1100111).
  - imm_i:
    - J-type imm {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} sign-extended to size when jump.
    - I-type imm instr[31:20] sign-extended when jalr.
    - 0 otherwise.
  - Predecode outputs are independent of full. Consumers qualify them with buble.
- Reset asserted mid-operation discards all entries immediately. No partial-entry state survives.

Test Plan:
- Reset, then imem_valid=1 with instr 32'h00500093 @ pc 0x0 → dec_valid=1 next cycle, dec_instr=32'h00500093, dec_pc=0; jump=0, jalr=0, imm_i=0.
- dec_ready=0, push 4 words (pc 0x0, 0x4, 0x8, 0xC) → buble=1 after the 4th edge; a 5th word (pc 0x10) held 3 cycles is not written; after one pop, pc 0x10 enqueues; pop order is 0x0, 0x4, 0x8, 0xC, 0x10.
- Full FIFO with dec_ready=1 and imem_valid=1 in the same cycle → count drops to 3, no write that cycle; the next cycle enq and deq together keep count at 3; pointer wrap is verified past index 3.
- 2 entries queued, flush=1 together with imem_valid=1 → next cycle dec_valid=0, buble=0, count=0; a following push of pc 0x100 appears at the head.
- imem_instr=32'hFF9FF06F (JAL x0,-8) → jump=1, imm_i=32'hFFFFFFF8. imem_instr=32'h00C08067 (JALR x1,12) → jalr=1, imm_i=32'h0000000C. Same words with flush=1 → jump=0, jalr=0.
- Reset pulsed low for half a cycle while 3 entries are queued → dec_valid=0 and dec_instr=32'h00000013 immediately (asynchronously); the first push after release appears alone.

Source files
------------

// File: rtl/fetch_instruction_buffer.sv
// Fetch-side instruction buffer: queues instruction/PC pairs from instruction memory for decode,
// stalls the PC controller when full, and predecodes the incoming word for next-PC formation.
module fetch_instruction_buffer #(
    parameter int size  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            imem_valid,
    input  logic [size-1:0] imem_instr,
    input  logic [size-1:0] imem_pc,
    input  logic            flush,
    input  logic            dec_ready,
    output logic            dec_valid,
    output logic [size-1:0] dec_instr,
    output logic [size-1:0] dec_pc,
    output logic            buble,
    output logic            jump,
    output logic            jalr,
    output logic [size-1:0] imm_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [size-1:0] NOP_INSTR  = size'(32'h0000_0013);
    localparam logic [6:0]      OPC_JAL    = 7'b1101111;
    localparam logic [6:0]      OPC_JALR   = 7'b1100111;

    logic [size-1:0] instr_mem [DEPTH];
    logic [size-1:0] pc_mem    [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic full;
    logic empty;
    logic enq;
    logic deq;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Flush wins over both sides; a full buffer refuses the word even when decode pops this cycle.
    assign enq = imem_valid & ~full & ~flush;
    assign deq = dec_valid & dec_ready & ~flush;

    // NOTE: storage has no reset; count/pointers alone decide what is visible, so contents are don't-care.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr] <= imem_instr;
            pc_mem[wr_ptr]    <= imem_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head presentation comes purely from registered state, so there is no imem-to-decode bypass.
    assign dec_valid = ~empty;
    assign buble     = full;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        dec_instr = NOP_INSTR;
        dec_pc    = '0;
        if (!empty) begin
            dec_instr = instr_mem[rd_ptr];
            dec_pc    = pc_mem[rd_ptr];
        end
    end

    // Predecode looks at the incoming word regardless of full; the PC controller qualifies with buble.
    logic [6:0]      opcode;
    logic [size-1:0] imm_j_ext;
    logic [size-1:0] imm_i_ext;

    assign opcode    = imem_instr[6:0];
    assign imm_j_ext = {{(size-21){imem_instr[31]}}, imem_instr[31], imem_instr[19:12],
                        imem_instr[20], imem_instr[30:21], 1'b0};
    assign imm_i_ext = {{(size-12){imem_instr[31]}}, imem_instr[31:20]};

    assign jump = imem_valid & ~flush & (opcode == OPC_JAL);
    assign jalr = imem_valid & ~flush & (opcode == OPC_JALR);

    always_comb begin
        imm_i = '0;
        if (jump)      imm_i = imm_j_ext;
        else if (jalr) imm_i = imm_i_ext;
    end

endmodule

// File: tb/tb_fetch_instruction_buffer.sv
// Self-checking bench for fetch_instruction_buffer: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_fetch_instruction_buffer;

    localparam int SIZE  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_valid;
    logic [SIZE-1:0] imem_instr;
    logic [SIZE-1:0] imem_pc;
    logic            flush;
    logic            dec_ready;
    logic            dec_valid;
    logic [SIZE-1:0] dec_instr;
    logic [SIZE-1:0] dec_pc;
    logic            buble;
    logic            jump;
    logic            jalr;
    logic [SIZE-1:0] imm_i;

    always #5 clk = ~clk;

    fetch_instruction_buffer #(.size(SIZE), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_valid (imem_valid),
        .imem_instr (imem_instr),
        .imem_pc    (imem_pc),
        .flush      (flush),
        .dec_ready  (dec_ready),
        .dec_valid  (dec_valid),
        .dec_instr  (dec_instr),
        .dec_pc     (dec_pc),
        .buble      (buble),
        .jump       (jump),
        .jalr       (jalr),
        .imm_i      (imm_i)
    );

    int checks = 0;
    int errors = 0;

    // Reference: queue of {instr, pc} in arrival order.
    logic [63:0] model_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_imm(input logic [31:0] w, input logic v, input logic fl);
        int val;
        val = 0;
        if (v && !fl) begin
            if (w[6:0] == 7'h6F)
                val = (w[31] ? -(1 << 20) : 0) + (int'(w[19:12]) << 12)
                      + (int'(w[20]) << 11) + (int'(w[30:21]) << 1);
            else if (w[6:0] == 7'h67)
                val = w[31] ? int'(w[31:20]) - 4096 : int'(w[31:20]);
        end
        return 32'(val);
    endfunction

    // One clock cycle: drive at negedge, check outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic fl, input logic rdy);
        logic exp_full;
        logic do_enq;
        logic do_deq;
        @(negedge clk);
        imem_valid = v;
        imem_instr = instr;
        imem_pc    = pc;
        flush      = fl;
        dec_ready  = rdy;
        #1;
        exp_full = (model_q.size() == DEPTH);
        check("dec_valid", 32'(dec_valid), 32'(model_q.size() != 0));
        check("dec_instr", dec_instr, model_q.size() != 0 ? model_q[0][63:32] : 32'h0000_0013);
        check("dec_pc", dec_pc, model_q.size() != 0 ? model_q[0][31:0] : 32'h0);
        check("buble", 32'(buble), 32'(exp_full));
        check("jump", 32'(jump), 32'(v && !fl && instr[6:0] == 7'h6F));
        check("jalr", 32'(jalr), 32'(v && !fl && instr[6:0] == 7'h67));
        check("imm_i", imm_i, model_imm(instr, v, fl));
        do_enq = v && !exp_full && !fl;
        do_deq = (model_q.size() != 0) && rdy && !fl;
        if (fl) model_q.delete();
        else begin
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) model_q.push_back({instr, pc});
        end
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, rdy);
    endtask

    initial begin
        logic [31:0] w;
        reset      = 1'b0;
        imem_valid = 1'b0;
        imem_instr = '0;
        imem_pc    = '0;
        flush      = 1'b0;
        dec_ready  = 1'b0;
        #1;
        check("rst_dec_valid", 32'(dec_valid), 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0000_0013);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_buble", 32'(buble), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single push: visible one cycle later.
        cycle(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        check("first_head_instr", dec_instr, 32'h0050_0093);
        idle(1'b1);

        // Fill with decode stalled, hold a fifth word, then drain.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h1000_0013 + i, 32'(4 * i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h1000_0113, 32'h10, 1'b0, 1'b0);
        check("full_buble", 32'(buble), 32'h1);
        cycle(1'b1, 32'h1000_0113, 32'h10, 1'b0, 1'b1);
        cycle(1'b1, 32'h1000_0113, 32'h10, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        idle(1'b0);

        // Full with simultaneous pop and push, then steady enq+deq across the pointer wrap.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h2000_0013 + i, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'h3000_0013 + i, 32'h300 + 32'(4 * i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Flush with two entries queued and a word arriving.
        cycle(1'b1, 32'h4000_0013, 32'h400, 1'b0, 1'b0);
        cycle(1'b1, 32'h4000_0093, 32'h404, 1'b0, 1'b0);
        cycle(1'b1, 32'h4000_0113, 32'h408, 1'b1, 1'b1);
        cycle(1'b1, 32'h5000_0013, 32'h100, 1'b0, 1'b0);
        idle(1'b0);
        check("post_flush_head_pc", dec_pc, 32'h100);
        idle(1'b1);

        // Predecode examples, with and without flush.
        cycle(1'b1, 32'hFF9F_F06F, 32'h500, 1'b0, 1'b1);
        check("jal_imm", imm_i, 32'hFFFF_FFF8);
        cycle(1'b1, 32'h00C0_8067, 32'h504, 1'b0, 1'b1);
        check("jalr_imm", imm_i, 32'h0000_000C);
        cycle(1'b1, 32'hFF9F_F06F, 32'h508, 1'b1, 1'b1);
        cycle(1'b1, 32'h00C0_8067, 32'h50C, 1'b1, 1'b1);

        // Asynchronous reset pulse with three entries queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h6000_0013 + i, 32'h600 + 32'(4 * i), 1'b0, 1'b0);
        @(negedge clk);
        imem_valid = 1'b0;
        dec_ready  = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(dec_valid), 32'h0);
        check("async_rst_instr", dec_instr, 32'h0000_0013);
        check("async_rst_pc", dec_pc, 32'h0);
        model_q.delete();
        #4 reset = 1'b1;
        cycle(1'b1, 32'h7000_0013, 32'h700, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w[6:0] = 7'h6F;
                1: w[6:0] = 7'h67;
                default: ;
            endcase
            cycle($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
